// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared scan states and active-low segment codes for the BCD display scanner.
package bcd_display_pkg;

    typedef enum logic [1:0] {UNITS, GAP_T, TENS, GAP_U} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_display_scanner_seg7_encoder.sv
// seg7_encoder: BCD digit to active-low {g..a} segments; non-decimal codes show "E".
module seg7_encoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = (bcd_i > 4'd9) ? SEG_ERR : SEG_LUT[bcd_i];

endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: latches a two-digit BCD value and time-multiplexes it onto
// a shared active-low segment bus with a one-cycle blank gap between digits.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       tens,
    input  logic [3:0] units,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_TERM = CW'(REFRESH_DIV - 1);

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic [3:0]    enc_in;
    logic [6:0]    enc_out;
    logic          slot_done, tens_dark;

    seg7_encoder u_enc (
        .bcd_i (enc_in),
        .seg_o (enc_out)
    );

    assign enc_in    = (state_q == TENS) ? {3'b000, tens_q} : units_q;
    assign slot_done = (state_q == GAP_T) || (state_q == GAP_U) || (cnt_q == CNT_TERM);
    assign tens_dark = blank_lz && !tens_q;

    always_comb begin
        tens_d  = load ? tens : tens_q;
        units_d = load ? units : units_q;
        // enum order is the scan order, so advancing wraps GAP_U back to UNITS
        state_d = slot_done ? scan_state_t'(state_q + 2'd1) : state_q;
        cnt_d   = slot_done ? '0 : cnt_q + 1'b1;
        an_d    = (state_q == UNITS) ? 2'b10 :
                  (state_q == TENS && !tens_dark) ? 2'b01 : 2'b11;
        seg_d   = (an_d == 2'b11) ? SEG_BLANK : enc_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNITS;
            cnt_q   <= '0;
            tens_q  <= 1'b0;
            units_q <= 4'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed stimulus checked every cycle against a scan-position model.
module tb_bcd_display_scanner;

    localparam int RD = 4;
    localparam int PERIOD = 2 * RD + 2;

    logic       clk = 1'b0;
    logic       rst, load, tens, blank_lz;
    logic [3:0] units;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int failures = 0;

    bcd_display_scanner #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .tens     (tens),
        .units    (units),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                     name, act[8:7], act[6:0], exp[8:7], exp[6:0]);
        end
    endtask

    // Model: outputs at an edge reflect scan position since reset and the value latched before that edge.
    bit         started = 0;
    int         k = 0;
    logic       m_t = 0;
    logic [3:0] m_u = 0;
    always begin
        logic [8:0] exp;
        int p;
        @(posedge clk);
        if (rst) begin
            exp = {2'b11, 7'h7F};
            k = 0; m_t = 0; m_u = 0; started = 1;
        end else begin
            p = k % PERIOD;
            if (p < RD) exp = {2'b10, lut[m_u]};
            else if (p > RD && p <= 2 * RD && !(blank_lz && !m_t)) exp = {2'b01, lut[{3'b0, m_t}]};
            else exp = {2'b11, 7'h7F};
            k++;
            if (load) begin m_t = tens; m_u = units; end
        end
        #1;
        if (started) begin
            check("model", {an, seg}, exp);
            check("an_not_both_low", {1'b0, an == 2'b00, 7'h0}, 9'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_val(input logic t, input logic [3:0] u);
        tens = t; units = u; load = 1;
        tick(1);
        load = 0;
    endtask

    task automatic wait_an(input logic [1:0] target);
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (an === target) break;
            tick(1);
        end
    endtask

    initial begin
        int tens_seen;
        rst = 1; load = 0; tens = 0; units = 0; blank_lz = 0;
        @(negedge clk);
        tick(2);
        check("reset_hold", {an, seg}, {2'b11, 7'h7F});
        rst = 0;
        tick(1);
        check("first_after_reset", {an, seg}, {2'b10, 7'h40});

        load_val(1'b1, 4'd5);
        tick(1);
        wait_an(2'b10);
        check("units_5", {an, seg}, {2'b10, 7'h12});
        wait_an(2'b01);
        check("tens_1", {an, seg}, {2'b01, 7'h79});
        tick(20);

        blank_lz = 1;
        load_val(1'b0, 4'd7);
        tick(1);
        wait_an(2'b10);
        check("units_7", {an, seg}, {2'b10, 7'h78});
        tens_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (an == 2'b01) tens_seen++;
            tick(1);
        end
        check("tens_blanked", {an, 7'(tens_seen)}, {an, 7'd0});
        blank_lz = 0;
        wait_an(2'b01);
        check("tens_0_shown", {an, seg}, {2'b01, 7'h40});

        load_val(1'b0, 4'hC);
        tick(1);
        wait_an(2'b10);
        check("units_err", {an, seg}, {2'b10, 7'h06});

        wait_an(2'b01);
        load_val(1'b0, 4'd3);
        check("tens_unchanged", {an, seg}, {2'b01, 7'h40});
        wait_an(2'b10);
        check("units_3_next_slot", {an, seg}, {2'b10, 7'h30});

        for (int i = 0; i < 12; i++) begin
            tens = 1'($urandom_range(0, 1));
            units = 4'($urandom_range(0, 15));
            load = 1;
            tick(1);
        end
        load = 0;
        tick(PERIOD);

        wait_an(2'b01);
        tick(1);
        rst = 1; load = 1; units = 4'd9; tens = 1;
        tick(1);
        check("reset_mid_tens", {an, seg}, {2'b11, 7'h7F});
        rst = 0; load = 0;
        tick(1);
        check("after_mid_reset", {an, seg}, {2'b10, 7'h40});
        tick(3 * PERIOD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Two-digit, time-multiplexed 7-segment scanner downstream of the binary-to-BCD decoder. It captures the decoder's tens bit (S4) and units nibble (S3..S0) on a load strobe and holds them. It drives one shared active-low segment bus plus two active-low digit enables. Digits alternate at a programmable refresh rate, with a one-cycle dead time between them to prevent ghosting.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture strobe; when high at an edge, tens/units are latched.
- tens  in  1  tens digit from decoder (S4); 0 or 1.
- units  in  4  units BCD digit from decoder ({S3,S2,S1,S0}, S3 = MSB).
- blank_lz  in  1  1 = suppress tens digit when latched tens is 0.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  2  digit enables, active-low; an[0] = units, an[1] = tens.

## Operation
- Holding registers tens_q and units_q reset to 0.
  - When load=1 at an edge, they capture tens/units.
  - When load=0, they hold.
- Scan FSM, 4 states:
  - UNITS: lasts REFRESH_DIV cycles, then GAP_T.
  - GAP_T: lasts 1 cycle, then TENS.
  - TENS: lasts REFRESH_DIV cycles, then GAP_U.
  - GAP_U: lasts 1 cycle, then UNITS.
  - Reset state is UNITS.
- Prescaler cnt, width $clog2(REFRESH_DIV):
  - Cleared on reset and on every state change.
  - Increments in UNITS/TENS.
  - Terminal value REFRESH_DIV-1 triggers the transition.
- Output mapping, computed from the state and holding registers after each edge:
  - UNITS: an=2'b10, seg=enc(units_q).
  - TENS: an=2'b01, seg=enc({3'b0,tens_q}).
    - If blank_lz=1 and tens_q=0, then instead an=2'b11, seg=7'h7F.
  - GAP_T/GAP_U: an=2'b11, seg=7'h7F.
- Encoder enc (active-low {g..a}): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes 10–15 show "E" = 06.
- blank_lz is sampled live, not latched.

## Timing
- seg and an are registered.
- Reset values: seg=7'h7F, an=2'b11, state=UNITS, cnt=0, tens_q=0, units_q=0.
- First edge after rst falls: an=2'b10, seg=7'h40.
- Load latency:
  - load high at edge N updates the holding registers at N.
  - seg reflects the new value at edge N+1, provided the relevant digit is active.
  - A load during a gap or the other digit's slot takes effect when that digit's slot begins.
- Scan period = 2·REFRESH_DIV + 2 cycles. Each digit duty = REFRESH_DIV / (2·REFRESH_DIV+2).
- Boundary conditions:
  - Load on the same edge as a state transition: new value, new state.
  - Load every cycle: the last value captured wins, with no glitch beyond one cycle.
  - rst and load together: rst wins; the registers clear.
  - rst mid-slot or mid-gap: on that edge, outputs return to reset values and the scan restarts at UNITS with cnt=0.
- an never has both bits low at any edge.

## Structure
- Package bcd_display_pkg holds:
  - typedef enum logic [1:0] scan_state_t {UNITS, GAP_T, TENS, GAP_U};
  - localparams SEG_BLANK=7'h7F and SEG_ERR=7'h06;
  - localparam array SEG_LUT[0:9] of segment codes.
- Sub-module seg7_encoder: combinational, 4-bit BCD in, 7-bit active-low segments out, SEG_ERR for inputs > 9. Instantiated once, with its input muxed by state.
- Top holds the FSM, prescaler, holding registers and output registers.

## Test plan
Run with REFRESH_DIV=4; the scan period is 10 cycles.
1. Reset: hold rst 3 cycles → seg=7F, an=11 each cycle. Release → next edge an=10, seg=40.
2. Load tens=1, units=5; observe 20 cycles → UNITS slot: an=10, seg=12 for 4 cycles. Gap: an=11, seg=7F for 1 cycle. TENS slot: an=01, seg=79 for 4 cycles. Then gap again.
3. blank_lz=1, load tens=0, units=7 → UNITS slots seg=78. TENS slots an=11, seg=7F. With blank_lz=0, TENS slots show an=01, seg=40.
4. Load units=4'hC → UNITS slot seg=06.
5. Load units=3 during a TENS slot → next UNITS slot seg=30. The TENS output is unchanged.
6. Reset asserted mid-TENS slot together with load=1 (units=9) → outputs 7F/11. After release: UNITS, seg=40.

Throughout all runs: assert an != 2'b00, and check the 10-cycle period.
